servo_seq_mux: RTL and testbench
================================

// Module: servo_seq_mux
// PURPOSE
//  Parametrised, clocked successor to the rover's combinational servo selector.
//  Holds a shadow/active duty register per servo channel and walks the enabled channels round-robin.
//  Advances to the next channel when the active channel's PWM generator reports period finished.
//  Drives the flattened duty bus into the per-servo PWM generators.
//  Sits between the command decoder (duty writes) and the servo PWM bank.
// PARAMETERS
//  NUM_SERVOS  4        number of servo channels (2..16)
//  DUTY_W      21       duty word width in clock ticks
//  DUTY_MAX    21'd200000  writes above this clamp to DUTY_MAX
//  IDX_W       $clog2(NUM_SERVOS)  channel index width (derived, do not override)
// PORTS
//  clk             in   1                    system clock
//  rst_n           in   1                    asynchronous active-low reset
//  enable          in   1                    1 = sequencer runs; 0 = return to IDLE
//  mode_all        in   1                    1 = drive every enabled channel; 0 = drive active channel only
//  chan_en         in   NUM_SERVOS           per-channel enable mask
//  wr_en           in   1                    shadow duty write strobe
//  wr_idx          in   IDX_W                channel written
//  wr_duty         in   DUTY_W               duty value written
//  period_finished in   NUM_SERVOS           1-cycle pulses from PWM generators
//  active_idx      out  IDX_W                channel currently selected
//  active_done     out  1                    period_finished[active_idx], combinational
//  seq_wrap        out  1                    1-cycle pulse when selection wraps to lowest enabled channel
//  servo_duty      out  NUM_SERVOS*DUTY_W    slice i = bits [i*DUTY_W +: DUTY_W]
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - all shadow/active regs = 0; state = IDLE.
//  - active_idx = 0; seq_wrap = 0; servo_duty = 0.
//  Shadow write:
//  - on wr_en, shadow[wr_idx] <= min(wr_duty, DUTY_MAX).
//  - wr_idx >= NUM_SERVOS is ignored.
//  - writes are accepted in every state.
//  Commit:
//  - active[i] <= shadow[i] only when channel i is latched by LOAD/ADVANCE.
//  - a write to the same channel in the commit cycle bypasses: the clamped wr_duty is committed.
//  FSM states IDLE, LOAD, RUN, ADVANCE:
//  - IDLE: enable=1 and chan_en!=0 -> LOAD; otherwise stay.
//  - LOAD: active_idx <= lowest set bit of chan_en; commit it -> RUN.
//  - RUN: period_finished[active_idx]=1 -> ADVANCE.
//  - RUN: chan_en[active_idx] cleared -> ADVANCE, without waiting for period end.
//  - ADVANCE: active_idx <= next set bit above active_idx, modulo NUM_SERVOS; commit it -> RUN.
//    seq_wrap=1 for one cycle if the new index <= the old one.
//  - any state: enable=0 or chan_en=0 -> IDLE next cycle; active regs are retained.
//  Latency:
//  - pulse seen at edge t -> ADVANCE at t+1 -> new active_idx and duty visible after edge t+2.
//  - pulses on non-active channels are ignored.
//  - a single enabled channel re-selects itself each period; seq_wrap pulses every period.
//  Output, registered (no combinational path from inputs):
//  - slice i = active[i] if chan_en[i] and (mode_all or i==active_idx) and state!=IDLE.
//  - otherwise slice i = 0.
//  - mode_all=0 reproduces the one-hot shifted bus of the previous generation.
// STRUCTURE
//  servo_pkg:
//  - state enum (2 bits) and the DUTY_MAX default constant.
//  - function next_enabled(mask, cur) -> {wrap, idx}: priority-encoded search above cur with wraparound.
//  One sub-module servo_next_sel wraps next_enabled as combinational logic; the rest stays flat.
//  Duty regs are flops, not RAM: all channels are driven every cycle.
// TESTING
//  1 Reset: rst_n=0 mid-RUN with nonzero duties -> servo_duty=0, active_idx=0, state IDLE; all asynchronous.
//  2 Round-robin: NUM_SERVOS=4, chan_en=4'b1111, duties 1000/2000/3000/4000, pulse period_finished[active_idx]
//    -> idx 0,1,2,3,0; seq_wrap on 3->0; duty changes 2 cycles after each pulse.
//  3 Sparse mask: chan_en=4'b1010 -> idx 1,3,1; clear bit 3 while idx=3 -> idx 1 without a pulse.
//  4 Clamp/bypass: write 21'h1FFFFF to ch2 -> shadow=DUTY_MAX;
//    write 500 to ch2 on the ADVANCE-into-2 cycle -> active[2]=500.
//  5 Mode: mode_all=1, chan_en=4'b0111 -> slices 0..2 = their duties, slice 3=0;
//    mode_all=0 -> only the active slice is nonzero.
//  6 Ignore: period_finished on a non-active channel, wr_idx>=NUM_SERVOS (NUM_SERVOS=3) -> no state/register change.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared state encoding, duty limit and the round-robin channel search for the servo sequencer.
// Pure declarations and combinational helpers; no latency, no backpressure.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        ADVANCE = 2'd3
    } seqState_t;

    localparam logic [20:0] DUTY_MAX_DEF = 21'd200000;
    localparam int          MAX_SERVOS   = 16;

    // Returns {wrap, idx}: first set bit strictly above cur, wrapping modulo n.
    // With only cur set the search lands back on cur and reports a wrap.
    function automatic logic [4:0] next_enabled(
        input logic [15:0] mask,
        input logic [3:0]  cur,
        input logic [4:0]  n
    );
        logic       found;
        logic [3:0] idx;
        logic [4:0] cand;
        found = 1'b0;
        idx   = cur;
        for (int k = 1; k <= MAX_SERVOS; k++) begin
            cand = {1'b0, cur} + 5'(k);
            if (cand >= n) begin
                cand = cand - n;
            end
            if (!found && (5'(k) <= n) && mask[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end
        end
        return {(idx <= cur), idx};
    endfunction

endpackage

// File: rtl/servo_next_sel.sv
// Combinational next-enabled-channel search with wrap flag.
// Zero latency; no backpressure.
module servo_next_sel
    import servo_pkg::*;
#(
    parameter int NUM_SERVOS = 4,
    parameter int IDX_W      = $clog2(NUM_SERVOS)
) (
    input  logic [NUM_SERVOS-1:0] mask,
    input  logic [IDX_W-1:0]      cur,
    output logic [IDX_W-1:0]      nextIdx,
    output logic                  wrap
);

    logic [4:0] sel;

    assign sel     = next_enabled(16'(mask), 4'(cur), 5'(NUM_SERVOS));
    assign nextIdx = IDX_W'(sel[3:0]);
    assign wrap    = sel[4];

endmodule

// File: rtl/servo_seq_mux.sv
// Round-robin servo duty sequencer: shadow/active duty per channel, registered duty bus to the PWM bank.
// Period-end pulse -> new selection two edges later; no backpressure, duty writes accepted every cycle.
module servo_seq_mux
    import servo_pkg::*;
#(
    parameter int                NUM_SERVOS = 4,
    parameter int                DUTY_W     = 21,
    parameter logic [DUTY_W-1:0] DUTY_MAX   = DUTY_W'(DUTY_MAX_DEF),
    parameter int                IDX_W      = $clog2(NUM_SERVOS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         mode_all,
    input  logic [NUM_SERVOS-1:0]        chan_en,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DUTY_W-1:0]            wr_duty,
    input  logic [NUM_SERVOS-1:0]        period_finished,
    output logic [IDX_W-1:0]             active_idx,
    output logic                         active_done,
    output logic                         seq_wrap,
    output logic [NUM_SERVOS*DUTY_W-1:0] servo_duty
);

    localparam int IDXP_W = IDX_W + 1;

    seqState_t                    state;
    seqState_t                    stateNxt;
    logic [IDX_W-1:0]             idxNxt;
    logic [IDX_W-1:0]             selIdx;
    logic [IDX_W-1:0]             searchFrom;
    logic                         selWrap;
    logic                         goIdle;
    logic                         commit;
    logic                         wrapNxt;
    logic                         wrIdxOk;
    logic [DUTY_W-1:0]            wrClamped;
    logic [DUTY_W-1:0]            shadow    [NUM_SERVOS];
    logic [DUTY_W-1:0]            active    [NUM_SERVOS];
    logic [DUTY_W-1:0]            shadowNxt [NUM_SERVOS];
    logic [DUTY_W-1:0]            activeNxt [NUM_SERVOS];
    logic [NUM_SERVOS*DUTY_W-1:0] dutyNxt;

    assign goIdle      = !enable || (chan_en == '0);
    assign wrIdxOk     = {1'b0, wr_idx} < IDXP_W'(NUM_SERVOS);
    assign wrClamped   = (wr_duty > DUTY_MAX) ? DUTY_MAX : wr_duty;
    assign active_done = period_finished[active_idx];

    // Searching above the top channel yields the lowest enabled one for LOAD.
    assign searchFrom = (state == LOAD) ? IDX_W'(NUM_SERVOS - 1) : active_idx;

    servo_next_sel #(
        .NUM_SERVOS (NUM_SERVOS),
        .IDX_W      (IDX_W)
    ) u_next_sel (
        .mask    (chan_en),
        .cur     (searchFrom),
        .nextIdx (selIdx),
        .wrap    (selWrap)
    );

    always_comb begin
        stateNxt = state;
        idxNxt   = active_idx;
        commit   = 1'b0;
        wrapNxt  = 1'b0;
        if (goIdle) begin
            stateNxt = IDLE;
        end else begin
            case (state)
                IDLE: stateNxt = LOAD;
                LOAD: begin
                    stateNxt = RUN;
                    idxNxt   = selIdx;
                    commit   = 1'b1;
                end
                RUN: begin
                    if (period_finished[active_idx] || !chan_en[active_idx]) begin
                        stateNxt = ADVANCE;
                    end
                end
                ADVANCE: begin
                    stateNxt = RUN;
                    idxNxt   = selIdx;
                    commit   = 1'b1;
                    wrapNxt  = selWrap;
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

    // Commit reads the post-write shadow so a same-cycle write bypasses straight into active.
    always_comb begin
        dutyNxt = '0;
        for (int i = 0; i < NUM_SERVOS; i++) begin
            shadowNxt[i] = shadow[i];
            if (wr_en && wrIdxOk && (wr_idx == IDX_W'(i))) begin
                shadowNxt[i] = wrClamped;
            end
            activeNxt[i] = active[i];
            if (commit && (idxNxt == IDX_W'(i))) begin
                activeNxt[i] = shadowNxt[i];
            end
            if ((stateNxt != IDLE) && chan_en[i] && (mode_all || (idxNxt == IDX_W'(i)))) begin
                dutyNxt[i*DUTY_W +: DUTY_W] = activeNxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active_idx <= '0;
            seq_wrap   <= 1'b0;
            servo_duty <= '0;
            for (int i = 0; i < NUM_SERVOS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state      <= stateNxt;
            active_idx <= idxNxt;
            seq_wrap   <= wrapNxt;
            servo_duty <= dutyNxt;
            for (int i = 0; i < NUM_SERVOS; i++) begin
                shadow[i] <= shadowNxt[i];
                active[i] <= activeNxt[i];
            end
        end
    end

endmodule

// File: tb/tb_servo_seq_mux.sv
// Scoreboarded bench for servo_seq_mux: selection-schedule reference model, directed and random stimulus.
module tb_servo_seq_mux;

    localparam int N    = 4;
    localparam int DW   = 21;
    localparam int DMAX = 200000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            modeAll;
    logic [N-1:0]    chanEn;
    logic [N-1:0]    pf;
    logic            wrEn;
    logic [1:0]      wrIdx;
    logic [DW-1:0]   wrDuty;
    logic [1:0]      activeIdx;
    logic            activeDone;
    logic            seqWrap;
    logic [N*DW-1:0] servoDuty;

    logic            en3;
    logic            mode3;
    logic            wrEn3;
    logic [2:0]      mask3;
    logic [2:0]      pf3;
    logic [1:0]      wrIdx3;
    logic [DW-1:0]   wrDuty3;
    logic [1:0]      idx3;
    logic            done3;
    logic            wrap3;
    logic [3*DW-1:0] duty3;

    always #5 clk = ~clk;

    servo_seq_mux #(.NUM_SERVOS(N)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode_all(modeAll), .chan_en(chanEn),
        .wr_en(wrEn), .wr_idx(wrIdx), .wr_duty(wrDuty), .period_finished(pf),
        .active_idx(activeIdx), .active_done(activeDone), .seq_wrap(seqWrap), .servo_duty(servoDuty)
    );

    servo_seq_mux #(.NUM_SERVOS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(en3), .mode_all(mode3), .chan_en(mask3),
        .wr_en(wrEn3), .wr_idx(wrIdx3), .wr_duty(wrDuty3), .period_finished(pf3),
        .active_idx(idx3), .active_done(done3), .seq_wrap(wrap3), .servo_duty(duty3)
    );

    typedef struct {
        logic [1:0]      idx;
        logic            wrap;
        logic            done;
        logic [N*DW-1:0] duty;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: a selection is "due" one edge after it is requested (start, period end, channel drop).
    int shadowM[N];
    int activeM[N];
    bit mRun;
    bit mSelDue;
    bit mSelFirst;
    int mIdx;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int lowestSet(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int nextAfter(input logic [N-1:0] m, input int cur);
        for (int d = 1; d <= N; d++) if (m[(cur + d) % N]) return (cur + d) % N;
        return cur;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            shadowM[i] = 0;
            activeM[i] = 0;
        end
        mRun = 0; mSelDue = 0; mSelFirst = 0; mIdx = 0;
    endtask

    // Predict the response to the inputs now driven, then advance one clock.
    task automatic cyc();
        exp_t e;
        bit   stop;
        int   pick;
        stop = !enable || (chanEn == '0);
        if (wrEn && (int'(wrIdx) < N)) shadowM[wrIdx] = (int'(wrDuty) > DMAX) ? DMAX : int'(wrDuty);
        e.wrap = 1'b0;
        if (stop) begin
            mRun = 0; mSelDue = 0;
        end else if (!mRun) begin
            mRun = 1; mSelDue = 1; mSelFirst = 1;
        end else if (mSelDue) begin
            pick = mSelFirst ? lowestSet(chanEn) : nextAfter(chanEn, mIdx);
            e.wrap = !mSelFirst && (pick <= mIdx);
            mIdx = pick;
            activeM[pick] = shadowM[pick];
            mSelDue = 0;
        end else if (pf[mIdx] || !chanEn[mIdx]) begin
            mSelDue = 1; mSelFirst = 0;
        end
        e.idx  = 2'(mIdx);
        e.done = pf[mIdx];
        e.duty = '0;
        for (int i = 0; i < N; i++)
            if (mRun && chanEn[i] && (modeAll || i == mIdx)) e.duty[i*DW +: DW] = DW'(activeM[i]);
        expQ.push_back(e);
        @(negedge clk);
        wrEn = 0; pf = '0; wrEn3 = 0; pf3 = '0;
    endtask

    task automatic pulseSel(input int ch, input int expIdx, input bit expWrap, input int expDuty);
        pf = 4'(1 << ch);
        cyc();
        cyc();
        check("sel_idx", activeIdx, expIdx);
        check("sel_wrap", seqWrap, expWrap);
        check("sel_duty", servoDuty[expIdx*DW +: DW], expDuty);
        cyc();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("sb_active_idx", activeIdx, e.idx);
                check("sb_seq_wrap", seqWrap, e.wrap);
                check("sb_active_done", activeDone, e.done);
                check("sb_servo_duty", servoDuty, e.duty);
            end
        end
    end

    initial begin : stim
        logic [N*DW-1:0] bus;
        logic [3*DW-1:0] bus3;
        rst_n = 0; enable = 0; modeAll = 0; chanEn = '0; pf = '0;
        wrEn = 0; wrIdx = '0; wrDuty = '0;
        en3 = 0; mode3 = 0; wrEn3 = 0; mask3 = '0; pf3 = '0; wrIdx3 = '0; wrDuty3 = '0;
        modelReset();
        repeat (3) @(negedge clk);
        check("rst_duty", servoDuty, 0);
        check("rst_idx", activeIdx, 0);
        check("rst_wrap", seqWrap, 0);
        rst_n = 1;

        // Round robin over all four channels
        for (int i = 0; i < N; i++) begin
            wrEn = 1; wrIdx = 2'(i); wrDuty = DW'((i + 1) * 1000);
            cyc();
        end
        enable = 1; chanEn = 4'b1111;
        repeat (3) cyc();
        check("load_idx", activeIdx, 0);
        check("load_duty", servoDuty, 1000);
        pulseSel(0, 1, 0, 2000);
        pulseSel(1, 2, 0, 3000);
        pulseSel(2, 3, 0, 4000);
        pulseSel(3, 0, 1, 1000);
        pulseSel(0, 1, 0, 2000);

        // Sparse mask, then drop the active channel
        chanEn = 4'b1010;
        cyc();
        pulseSel(1, 3, 0, 4000);
        pulseSel(3, 1, 1, 2000);
        pulseSel(1, 3, 0, 4000);
        chanEn = 4'b0010;
        cyc();
        cyc();
        check("drop_idx", activeIdx, 1);
        check("drop_wrap", seqWrap, 1);
        cyc();

        // Clamp and commit-cycle bypass
        chanEn = 4'b1111;
        wrEn = 1; wrIdx = 2; wrDuty = 21'h1FFFFF;
        cyc();
        pulseSel(1, 2, 0, DMAX);
        pulseSel(2, 3, 0, 4000);
        pulseSel(3, 0, 1, 1000);
        pulseSel(0, 1, 0, 2000);
        pf = 4'b0010;
        cyc();
        wrEn = 1; wrIdx = 2; wrDuty = 500;
        cyc();
        check("bypass_idx", activeIdx, 2);
        check("bypass_duty", servoDuty[2*DW +: DW], 500);
        cyc();

        // Drive-all vs one-hot bus
        modeAll = 1; chanEn = 4'b0111;
        cyc();
        bus = {21'd0, 21'd500, 21'd2000, 21'd1000};
        check("mode_all_bus", servoDuty, bus);
        modeAll = 0;
        cyc();
        bus = {21'd0, 21'd500, 21'd0, 21'd0};
        check("mode_one_bus", servoDuty, bus);

        // Pulses on inactive channels are ignored
        pf = 4'b1011;
        cyc();
        pf = 4'b0011;
        cyc();
        cyc();
        check("ignore_idx", activeIdx, 2);

        // Three-channel instance: wrap modulo 3 and out-of-range write
        wrEn3 = 1; wrIdx3 = 0; wrDuty3 = 100; cyc();
        wrEn3 = 1; wrIdx3 = 1; wrDuty3 = 200; cyc();
        wrEn3 = 1; wrIdx3 = 2; wrDuty3 = 300; cyc();
        en3 = 1; mask3 = 3'b111; mode3 = 1;
        repeat (3) cyc();
        check("n3_load_idx", idx3, 0);
        pf3 = 3'b110;
        cyc();
        cyc();
        check("n3_ignore_idx", idx3, 0);
        for (int k = 0; k < 3; k++) begin
            pf3 = 3'(1 << k);
            cyc();
            cyc();
            check("n3_idx", idx3, (k + 1) % 3);
            check("n3_wrap", wrap3, (k == 2));
            cyc();
        end
        bus3 = {21'd300, 21'd200, 21'd100};
        check("n3_bus", duty3, bus3);
        wrEn3 = 1; wrIdx3 = 3; wrDuty3 = 999;
        cyc();
        for (int k = 0; k < 3; k++) begin
            pf3 = 3'(1 << k);
            repeat (3) cyc();
        end
        check("n3_oob_bus", duty3, bus3);

        // Randomised traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) chanEn = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) modeAll = ~modeAll;
            pf = ($urandom_range(0, 3) == 0) ? 4'(1 << mIdx) : 4'b0000;
            if ($urandom_range(0, 7) == 0) pf = pf | 4'($urandom_range(0, 15));
            wrEn = ($urandom_range(0, 2) == 0);
            wrIdx = 2'($urandom_range(0, 3));
            wrDuty = DW'($urandom_range(0, 21'h1FFFFF));
            cyc();
        end

        // Asynchronous reset in the middle of RUN
        enable = 1; chanEn = 4'b1111; modeAll = 1;
        for (int i = 0; i < N; i++) begin
            wrEn = 1; wrIdx = 2'(i); wrDuty = DW'($urandom_range(1, DMAX));
            cyc();
        end
        repeat (8) begin
            pf = 4'(1 << mIdx);
            cyc();
            cyc();
        end
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check("arst_duty", servoDuty, 0);
        check("arst_idx", activeIdx, 0);
        check("arst_wrap", seqWrap, 0);
        check("arst_duty3", duty3, 0);
        @(negedge clk);
        @(negedge clk);
        modelReset();
        rst_n = 1;
        repeat (6) cyc();
        check("post_rst_duty", servoDuty, 0);

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
